debug_frame_sender: RTL and testbench
=====================================

DEBUG_FRAME_SENDER -- requirements
Module: debug_frame_sender

Interface
REQ-001 Parameter WIDTH, default 40: payload bits per frame (>=2).
REQ-002 Parameter DEPTH, default 4: FIFO entries (power of 2, >=2).
REQ-003 Parameter GAP, default 5: idle bit periods after each frame (>=0).
REQ-004 Parameter BIT_DIV, default 1: clk cycles per serial bit (>=1).
REQ-005 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 shifted first, 0 = bit 0 first.
REQ-006 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-007 clk  input  1  sole clock, all state on rising edge.
REQ-008 reset  input  1  asynchronous active-high reset.
REQ-009 in_valid  input  1  in_data offered this cycle.
REQ-010 in_data  input  WIDTH  payload word.
REQ-011 in_ready  output  1  FIFO can accept; equals (level != DEPTH).
REQ-012 sout  output  1  serial data, registered.
REQ-013 sframe  output  1  high during the first bit period of each frame, registered.
REQ-014 busy  output  1  high in SHIFT or GAP state.
REQ-015 level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 overflow  output  1  sticky: set when in_valid && !in_ready.

Function
REQ-017 Push occurs on in_valid && in_ready; in_ready does not depend on a same-cycle pop (full + pop + push -> push refused, overflow set).
REQ-018 Word offered while full is dropped, not stored; overflow stays 1 until reset.
REQ-019 FSM states IDLE, SHIFT, GAP; pop only in IDLE with level>0 (or at the final GAP/SHIFT bit boundary, see REQ-023).
REQ-020 Pop loads shift register, resets bit counter and divider, enters SHIFT; first bit on sout in the cycle after the pop edge, sframe=1 for that bit period.
REQ-021 Push into empty FIFO while IDLE: first frame bit appears on sout 2 cycles after the push edge.
REQ-022 SHIFT: each bit held exactly BIT_DIV cycles; after WIDTH bits go to GAP (GAP>0), else apply REQ-023.
REQ-023 At end of GAP (or of SHIFT when GAP=0): level>0 -> pop and start next frame with no extra cycle; else IDLE.
REQ-024 sout=0 and sframe=0 in IDLE and GAP.
REQ-025 Frame length is exactly (WIDTH+GAP)*BIT_DIV cycles; back-to-back frames gapless beyond GAP.
REQ-026 Pointers wrap modulo DEPTH; level arithmetic saturates at neither end (guarded by in_ready/empty).
REQ-027 Simultaneous push and pop with 0<level<DEPTH: level unchanged.

Reset
REQ-028 reset asserted (any time, incl. mid-frame): immediately FSM=IDLE, FIFO empty, level=0, in_ready=1, sout=0, sframe=0, busy=0, overflow=0, counters 0.
REQ-029 First push accepted on the first rising clk edge after reset deasserts.

Structure
REQ-030 Shared package holds FSM state encoding (IDLE/SHIFT/GAP) and the default parameter constants.
REQ-031 FIFO is one sub-module, debug_sync_fifo (WIDTH, DEPTH parameters, push/pop/level/full/empty).
REQ-032 No combinational path from in_valid to any output.

Verification (bench: WIDTH=8, DEPTH=2, GAP=2, BIT_DIV=1 unless stated)
REQ-033 Push 0x03, MSB_FIRST=1 -> sout 0,0,0,0,0,0,1,1 on cycles 2..9 after push, sframe=1 only at cycle 2, then 2 zero cycles, busy falls.
REQ-034 Push 0x03, MSB_FIRST=0 -> sout 1,1,0,0,0,0,0,0; same timing.
REQ-035 Push 0x11,0x22,0x33 on consecutive cycles -> all accepted, three frames, sframe pulses exactly 10 cycles apart.
REQ-036 Hold FIFO full (level=2, in_ready=0), push 0x55 -> 0x55 never transmitted, overflow=1 until reset.
REQ-037 Assert reset during bit 3 of frame -> same cycle sout=0, busy=0, level=0, in_ready=1; next push transmits cleanly.
REQ-038 BIT_DIV=3, push 0xA5 -> each bit held 3 cycles, frame+gap = 30 cycles.

Source files
------------

// File: rtl/debug_frame_sender_pkg.sv
// ---------------------------------------------------------------------------
// debug_frame_sender_pkg
// Shared definitions for the debug frame sender and its FIFO:
//   - default parameter constants for the sender
//   - FSM state encoding (IDLE / SHIFT / GAP)
//   - a helper that sizes counters from their largest count
// No ports; imported by debug_sync_fifo and debug_frame_sender.
// ---------------------------------------------------------------------------
package debug_frame_sender_pkg;

    localparam int DEFAULT_WIDTH     = 40;
    localparam int DEFAULT_DEPTH     = 4;
    localparam int DEFAULT_GAP       = 5;
    localparam int DEFAULT_BIT_DIV   = 1;
    localparam int DEFAULT_MSB_FIRST = 1;

    // Serializer states: waiting for data, shifting payload bits, idle gap.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Bits needed to hold counts 0 .. num_values-1 (never less than 1 bit).
    function automatic int cnt_width(input int num_values);
        return (num_values < 2) ? 1 : $clog2(num_values);
    endfunction

endpackage

// File: rtl/debug_frame_sender_fifo.sv
// ---------------------------------------------------------------------------
// debug_sync_fifo
// Single-clock first-word-fall-through FIFO feeding the frame serializer.
// rd_data always shows the oldest entry, so a pop can load it in the
// same cycle.
// Ports:
//   clk      sole clock, rising edge
//   reset    asynchronous active-high reset (empties the FIFO)
//   push     write wr_data (ignored while full)
//   wr_data  word to store
//   pop      discard the oldest entry (ignored while empty)
//   rd_data  oldest entry
//   level    occupancy, 0 .. DEPTH
//   full     level == DEPTH
//   empty    level == 0
// ---------------------------------------------------------------------------
module debug_sync_fifo
    import debug_frame_sender_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Guard both sides locally so the occupancy can never wrap.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because level marks validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/debug_frame_sender.sv
// ---------------------------------------------------------------------------
// debug_frame_sender
// Buffers payload words in a small FIFO and sends each one as a serial
// frame: WIDTH payload bits, each held BIT_DIV cycles, followed by GAP idle
// bit periods. Frames queued in the FIFO follow each other with no extra
// idle cycle beyond the gap.
// Ports:
//   clk       sole clock, rising edge
//   reset     asynchronous active-high reset
//   in_valid  in_data offered this cycle
//   in_data   payload word
//   in_ready  FIFO can accept (level != DEPTH)
//   sout      serial data, registered
//   sframe    high during the first bit period of a frame, registered
//   busy      high while shifting or in the gap
//   level     FIFO occupancy
//   overflow  sticky: a word was offered while the FIFO was full
// ---------------------------------------------------------------------------
module debug_frame_sender
    import debug_frame_sender_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int GAP       = DEFAULT_GAP,
    parameter int BIT_DIV   = DEFAULT_BIT_DIV,
    parameter int MSB_FIRST = DEFAULT_MSB_FIRST
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     sout,
    output logic                     sframe,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    // The bit counter also counts gap periods, so size it for the larger.
    localparam int BIT_W = cnt_width((WIDTH > GAP) ? WIDTH : GAP);
    localparam int DIV_W = cnt_width(BIT_DIV);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_GAP = BIT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(BIT_DIV - 1);

    state_t           state;
    state_t           next_state;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;

    logic [WIDTH-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;

    logic             bit_end;
    logic             shift_done;
    logic             gap_done;
    logic             frame_end;
    logic             cur_bit;
    logic             sout_next;
    logic             sframe_next;

    // in_ready comes from registered occupancy only, so a pop in the same
    // cycle never opens room for a push and in_valid reaches no output.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    debug_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Timing decodes: end of a bit period, last payload bit, last gap bit.
    // frame_end is where the next queued word may be popped without a
    // lost cycle; with no gap that is the last payload bit itself.
    assign bit_end    = (div_cnt == LAST_DIV);
    assign shift_done = (state == ST_SHIFT) && bit_end && (bit_cnt == LAST_BIT);
    assign gap_done   = (state == ST_GAP) && bit_end && (bit_cnt == LAST_GAP);
    assign frame_end  = gap_done || (shift_done && (GAP == 0));
    assign cur_bit    = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    if (GAP > 0) begin
                        next_state = ST_GAP;
                    end else begin
                        next_state = fifo_empty ? ST_IDLE : ST_SHIFT;
                    end
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    next_state = fifo_empty ? ST_IDLE : ST_SHIFT;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // FSM outputs. sout/sframe are computed here and registered below, so
    // the serial line trails the state register by one cycle.
    always_comb begin
        pop         = 1'b0;
        busy        = 1'b0;
        sout_next   = 1'b0;
        sframe_next = 1'b0;
        if (!fifo_empty && ((state == ST_IDLE) || frame_end)) begin
            pop = 1'b1;
        end
        if (state != ST_IDLE) begin
            busy = 1'b1;
        end
        if (state == ST_SHIFT) begin
            sout_next   = cur_bit;
            sframe_next = (bit_cnt == '0);
        end
    end

    // Shift register and counters. A pop loads the next word and restarts
    // both counters; otherwise the divider paces bits and the bit counter
    // walks through payload bits and then gap periods.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (pop) begin
            shreg   <= fifo_rd_data;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (state != ST_IDLE) begin
            if (bit_end) begin
                div_cnt <= '0;
                if (shift_done || gap_done) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
                if (state == ST_SHIFT) begin
                    if (MSB_FIRST != 0) begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg <= {1'b0, shreg[WIDTH-1:1]};
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Registered serial outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sout   <= 1'b0;
            sframe <= 1'b0;
        end else begin
            sout   <= sout_next;
            sframe <= sframe_next;
        end
    end

endmodule

// File: tb/tb_debug_frame_sender.sv
// ---------------------------------------------------------------------------
// tb_debug_frame_sender
// Three senders (WIDTH=8, DEPTH=2, GAP=2) share one stimulus stream:
//   channel 0: MSB first, BIT_DIV=1
//   channel 1: LSB first, BIT_DIV=1
//   channel 2: MSB first, BIT_DIV=3
// Accepted words are queued per channel; a monitor pops a word at every
// frame start and checks the serial bits, sframe width and gap against a
// bit model of that channel.
// ---------------------------------------------------------------------------
module tb_debug_frame_sender;

    typedef struct {
        int         ch;
        logic [7:0] word;
    } exp_t;

    typedef enum int {M_IDLE, M_BITS, M_GAP} mon_phase_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;

    logic [2:0] in_ready_w;
    logic [2:0] sout_w;
    logic [2:0] sframe_w;
    logic [2:0] busy_w;
    logic [2:0] overflow_w;
    logic [1:0] level_w [3];

    int         tests;
    int         fails;
    int         cyc;
    int         push_cyc;
    int         p0;
    exp_t       exp_q[$];
    int         sf_times[$];

    mon_phase_t phase [3];
    int         idx [3];
    logic [23:0] got [3];
    logic [7:0] cur_word [3];
    logic       have_word [3];
    logic       sf_bad [3];
    logic       gap_bad [3];

    debug_frame_sender #(
        .WIDTH(8), .DEPTH(2), .GAP(2), .BIT_DIV(1), .MSB_FIRST(1)
    ) u_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_w[0]), .sout(sout_w[0]), .sframe(sframe_w[0]),
        .busy(busy_w[0]), .level(level_w[0]), .overflow(overflow_w[0])
    );

    debug_frame_sender #(
        .WIDTH(8), .DEPTH(2), .GAP(2), .BIT_DIV(1), .MSB_FIRST(0)
    ) u_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_w[1]), .sout(sout_w[1]), .sframe(sframe_w[1]),
        .busy(busy_w[1]), .level(level_w[1]), .overflow(overflow_w[1])
    );

    debug_frame_sender #(
        .WIDTH(8), .DEPTH(2), .GAP(2), .BIT_DIV(3), .MSB_FIRST(1)
    ) u_div (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_w[2]), .sout(sout_w[2]), .sframe(sframe_w[2]),
        .busy(busy_w[2]), .level(level_w[2]), .overflow(overflow_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int ch_div(input int ch);
        return (ch == 2) ? 3 : 1;
    endfunction

    function automatic bit ch_msb(input int ch);
        return (ch != 1);
    endfunction

    // Expected serial stream: sample k carries payload bit k/BIT_DIV.
    function automatic logic [23:0] expect_stream(input logic [7:0] word, input int ch);
        logic [23:0] s;
        int          div;
        int          j;
        s   = '0;
        div = ch_div(ch);
        for (int k = 0; k < 8 * div; k++) begin
            j    = k / div;
            s[k] = ch_msb(ch) ? word[7-j] : word[j];
        end
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Offer one word for one cycle; called right after a falling edge and
    // returns after the next falling edge with push_cyc = the push edge.
    task automatic applyStimulus(input logic [7:0] word, input bit accept);
        exp_t e;
        in_valid = 1'b1;
        in_data  = word;
        if (accept) begin
            for (int ch = 0; ch < 3; ch++) begin
                e.ch   = ch;
                e.word = word;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: samples every channel on the falling edge, pops the expected
    // word at each frame start, then checks payload bits and the gap.
    always @(negedge clk) begin
        for (int ch = 0; ch < 3; ch++) begin
            int div;
            div = ch_div(ch);
            if (reset) begin
                phase[ch] = M_IDLE;
                for (int i = exp_q.size() - 1; i >= 0; i--) begin
                    if (exp_q[i].ch == ch) exp_q.delete(i);
                end
            end else begin
                case (phase[ch])
                    M_IDLE: begin
                        if (sframe_w[ch]) begin
                            if (ch == 0) sf_times.push_back(cyc);
                            have_word[ch] = 1'b0;
                            for (int i = 0; i < exp_q.size(); i++) begin
                                if (exp_q[i].ch == ch) begin
                                    cur_word[ch]  = exp_q[i].word;
                                    have_word[ch] = 1'b1;
                                    exp_q.delete(i);
                                    break;
                                end
                            end
                            if (!have_word[ch]) begin
                                tests++;
                                fails++;
                                $display("[TB] FAIL ch%0d_unexpected_frame: frame started with no word queued (cycle %0d)",
                                         ch, cyc);
                            end
                            got[ch]    = '0;
                            got[ch][0] = sout_w[ch];
                            idx[ch]    = 1;
                            sf_bad[ch] = 1'b0;
                            phase[ch]  = M_BITS;
                        end
                    end
                    M_BITS: begin
                        got[ch][idx[ch]] = sout_w[ch];
                        if (sframe_w[ch] != (idx[ch] < div)) sf_bad[ch] = 1'b1;
                        idx[ch]++;
                        if (idx[ch] == 8 * div) begin
                            if (have_word[ch]) begin
                                checkOutput($sformatf("ch%0d_frame_%02h", ch, cur_word[ch]),
                                            32'(got[ch]), 32'(expect_stream(cur_word[ch], ch)));
                                checkOutput($sformatf("ch%0d_sframe_width", ch),
                                            32'(sf_bad[ch]), 0);
                            end
                            idx[ch]     = 0;
                            gap_bad[ch] = 1'b0;
                            phase[ch]   = M_GAP;
                        end
                    end
                    default: begin
                        if (sout_w[ch] || sframe_w[ch]) gap_bad[ch] = 1'b1;
                        idx[ch]++;
                        if (idx[ch] == 2 * div) begin
                            checkOutput($sformatf("ch%0d_gap_quiet", ch), 32'(gap_bad[ch]), 0);
                            phase[ch] = M_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_level",    32'(level_w[0]),    0);
        checkOutput("reset_in_ready", 32'(in_ready_w[0]), 1);
        checkOutput("reset_sout",     32'(sout_w),        0);
        checkOutput("reset_sframe",   32'(sframe_w),      0);
        checkOutput("reset_busy",     32'(busy_w),        0);
        checkOutput("reset_overflow", 32'(overflow_w),    0);

        // Single word 0x03, pushed on the first edge after reset.
        reset = 1'b0;
        sf_times.delete();
        applyStimulus(8'h03, 1'b1);
        checkOutput("first_push_level", 32'(level_w[0]),    1);
        checkOutput("first_push_ready", 32'(in_ready_w[0]), 1);
        waitUntil(push_cyc + 10);
        checkOutput("single_busy_last_gap", 32'(busy_w[1:0]), 32'h3);
        waitUntil(push_cyc + 11);
        checkOutput("single_busy_fell", 32'(busy_w[1:0]), 0);
        checkOutput("single_sframe_count", sf_times.size(), 1);
        if (sf_times.size() >= 1)
            checkOutput("single_latency", sf_times[0] - push_cyc, 2);
        waitUntil(push_cyc + 30);
        checkOutput("div3_busy_last_gap", 32'(busy_w[2]), 1);
        waitUntil(push_cyc + 31);
        checkOutput("div3_busy_fell", 32'(busy_w[2]), 0);

        // Burst of three, then a word offered while full is dropped.
        sf_times.delete();
        applyStimulus(8'h11, 1'b1);
        p0 = push_cyc;
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b1);
        checkOutput("burst_level_full", 32'(level_w[0]),    2);
        checkOutput("burst_not_ready",  32'(in_ready_w[0]), 0);
        checkOutput("burst_no_overflow", 32'(overflow_w),   0);
        applyStimulus(8'h55, 1'b0);
        checkOutput("drop_overflow_set", 32'(overflow_w),   32'h7);
        checkOutput("drop_level_held",   32'(level_w[0]),   2);
        waitUntil(p0 + 100);
        checkOutput("burst_sframe_count", sf_times.size(), 3);
        if (sf_times.size() == 3) begin
            checkOutput("burst_first_latency", sf_times[0] - p0, 2);
            checkOutput("burst_spacing_1", sf_times[1] - sf_times[0], 10);
            checkOutput("burst_spacing_2", sf_times[2] - sf_times[1], 10);
        end
        checkOutput("overflow_sticky", 32'(overflow_w), 32'h7);
        checkOutput("burst_drained_level", 32'(level_w[0]), 0);

        // Reset during bit 3 of a frame, then a clean frame afterwards.
        applyStimulus(8'h5A, 1'b1);
        waitUntil(push_cyc + 5);
        checkOutput("midframe_bit3", 32'(sout_w[0]), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_sout",     32'(sout_w),        0);
        checkOutput("midreset_busy",     32'(busy_w),        0);
        checkOutput("midreset_level",    32'(level_w[0]),    0);
        checkOutput("midreset_ready",    32'(in_ready_w),    32'h7);
        checkOutput("midreset_overflow", 32'(overflow_w),    0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sf_times.delete();
        applyStimulus(8'hC3, 1'b1);
        waitUntil(push_cyc + 11);
        checkOutput("after_reset_busy_fell", 32'(busy_w[0]), 0);
        checkOutput("after_reset_sframes", sf_times.size(), 1);
        waitUntil(push_cyc + 32);

        // BIT_DIV=3 frame of 0xA5: 30 busy cycles.
        applyStimulus(8'hA5, 1'b1);
        waitUntil(push_cyc + 30);
        checkOutput("a5_div3_busy_end", 32'(busy_w[2]), 1);
        waitUntil(push_cyc + 31);
        checkOutput("a5_div3_busy_fell", 32'(busy_w[2]), 0);
        repeat (2) @(negedge clk);

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
